obstacle_wave_walker: RTL and testbench
=======================================

Name: obstacle_wave_walker

Overview:
- Sequential consumer of the obstacle spawn-position ROM (3-bit index in, two start points out).
- Selects a wave index pseudo-randomly and presents it to the ROM. Latches the two returned start points into obstacles A (x0,y0) and B (x1,y1).
- Moves both obstacles vertically, one step per frame tick, until both leave the track. Feeds sprite renderer and game-control FSM.

Parameters:
- STEP, 2, vertical pixels moved per frame_tick (1..15)
- Y_MAX, 10'h262, far track bound; also ROM's bottom spawn row
- Y_MID, 10'h131, start-y threshold: below → moves down, at/above → moves up
- LFSR_SEED, 3'b001, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request new wave; sampled only in IDLE
- frame_tick  in  1  one-cycle pulse per video frame
- rom_index  out  3  index driven to position ROM
- rom_x0, rom_y0, rom_x1, rom_y1  in  10 each  ROM outputs, combinational from rom_index
- a_x, a_y, b_x, b_y  out  10 each  current obstacle positions
- a_active, b_active  out  1 each  obstacle on track
- busy  out  1  wave in progress (state != IDLE)
- done  out  1  one-cycle pulse, wave finished

Behaviour:
- Reset (rst_n low at clk edge), all outputs: positions 0, actives 0, busy 0, done 0, rom_index 0. State IDLE; lfsr = LFSR_SEED.
- rst_n low mid-wave aborts the wave immediately, with no done pulse.
- LFSR is 3-bit Fibonacci: next = {l[1:0], l[2]^l[1]}.
  - Period 7: 001→010→101→011→111→110→100→001.
- States:
  - IDLE: busy=0. If start=1 → SELECT; lfsr advances once on this edge.
  - SELECT: if lfsr==7, advance again and stay. Otherwise rom_index = lfsr−1 (range 0..5), registered → LOAD.
  - LOAD: ROM outputs settle this cycle; latch a_x/a_y ← rom_x0/rom_y0 and b_x/b_y ← rom_x1/rom_y1. Set both actives; latch each direction bit (dir=up if start y ≥ Y_MID) → RUN.
  - RUN: on frame_tick, each active obstacle steps. Frame ticks in SELECT/LOAD are ignored.
  - DONE: done=1 for exactly one cycle → IDLE. start is not sampled in DONE.
- Step arithmetic, done in 11 bits:
  - Down: s = y + STEP. If s ≥ Y_MAX: y = Y_MAX, active = 0. Otherwise y = s.
  - Up: if y ≤ STEP: y = 0, active = 0. Otherwise y = y − STEP.
- An obstacle that becomes inactive freezes its position. RUN → DONE on the cycle after both actives are 0.
- Latency: start at edge k → busy at k+1 → positions valid at k+3 (k+4 if a 7 was skipped).
- frame_tick and the final retire on the same edge: retire takes effect; DONE follows on the next edge.
- start held high: after DONE, IDLE re-samples it, so waves run back-to-back.

Optional Feature:
- Macro OBSTACLE_HIT_EN.
- Defined:
  - Adds inputs player_x[9:0], player_y[9:0] and output hit (1), plus parameters HIT_W=10'd32 and HIT_H=10'd48.
  - In RUN, on frame_tick, the check uses pre-step positions. Any active obstacle with |x−player_x| < HIT_W and |y−player_y| < HIT_H → hit pulses 1 cycle, both actives clear, state → DONE.
  - A and B colliding on the same tick gives a single hit pulse.
- Undefined: these ports and parameters are absent; no hit logic.

Decomposition:
- Shared include race_defs.vh: lane X constants (10'hc5, 10'h117, 10'h169), Y_MAX, Y_MID, state encodings (IDLE/SELECT/LOAD/RUN/DONE), STEP default.
- One sub-module: lane_lfsr (clk, rst_n, advance, value[2:0]; seed parameter), reusable by other spawners.

Test Plan:
- Reset with LFSR_SEED=001, then start pulse → lfsr 010, rom_index=1. In LOAD: a=(0xc5,0), b=(0x117,0), both down. After 305 frame_ticks, both y=0x262 and both inactive; done pulses once.
- Second wave → rom_index=4. a=(0x169,0) moving down, b=(0xc5,0x262) moving up. After tick 1, a_y=2 and b_y=0x260. After 305 ticks, a_y=0x262 and b_y=0.
- Fourth wave (lfsr hits 111) → skip observed; rom_index=5, latency +1 cycle.
- rst_n low at tick 100 of a wave → next edge: all outputs 0, busy 0, no done. Next start → rom_index=1 again.
- frame_tick asserted every cycle, and during SELECT/LOAD → no movement before RUN. start held high → done pulse, then IDLE for 1 cycle, then new wave.
- OBSTACLE_HIT_EN, index 1, player=(0xc5,0x40) → hit on the tick where a_y reaches 0x12; done next cycle.

Source files
------------

// File: rtl/obstacle_wave_walker_pkg.sv
// Shared definitions for the obstacle wave walker: lane/track constants, FSM states,
// obstacle record and the per-frame step arithmetic.
package obstacle_wave_walker_pkg;

  localparam logic [9:0] LaneX0  = 10'h0c5;
  localparam logic [9:0] LaneX1  = 10'h117;
  localparam logic [9:0] LaneX2  = 10'h169;
  localparam logic [9:0] YMaxDef = 10'h262;
  localparam logic [9:0] YMidDef = 10'h131;
  localparam logic [3:0] StepDef = 4'd2;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StLoad,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       up;
  } obstacle_t;

  function automatic logic [2:0] lfsr_next(input logic [2:0] l);
    return {l[1:0], l[2] ^ l[1]};
  endfunction

  // Inactive obstacles are returned unchanged so a retired one stays frozen.
  function automatic obstacle_t obstacle_step(input obstacle_t o, input logic [3:0] step,
                                              input logic [9:0] y_max);
    obstacle_t   r;
    logic [10:0] s;
    r = o;
    s = {1'b0, o.y} + {7'b0, step};
    if (o.active) begin
      if (o.up) begin
        if ({1'b0, o.y} <= {7'b0, step}) begin
          r.y      = '0;
          r.active = 1'b0;
        end else begin
          r.y = o.y - {6'b0, step};
        end
      end else begin
        if (s >= {1'b0, y_max}) begin
          r.y      = y_max;
          r.active = 1'b0;
        end else begin
          r.y = s[9:0];
        end
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/lane_lfsr.sv
// 3-bit Fibonacci LFSR (period 7) used to pick spawn waves; advances only on request.
module lane_lfsr
  import obstacle_wave_walker_pkg::*;
#(
  parameter logic [2:0] SEED = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [2:0] value
);

  logic [2:0] value_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else if (advance) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/obstacle_wave_walker.sv
// Picks a spawn wave, latches two obstacles from the position ROM and walks them off the track.
// Optional player collision detection is built when OBSTACLE_HIT_EN is defined.
module obstacle_wave_walker
  import obstacle_wave_walker_pkg::*;
#(
  parameter logic [3:0] STEP      = StepDef,
  parameter logic [9:0] Y_MAX     = YMaxDef,
  parameter logic [9:0] Y_MID     = YMidDef,
  parameter logic [2:0] LFSR_SEED = 3'b001
`ifdef OBSTACLE_HIT_EN
  ,
  parameter logic [9:0] HIT_W     = 10'd32,
  parameter logic [9:0] HIT_H     = 10'd48
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
  output logic [2:0] rom_index,
  input  logic [9:0] rom_x0,
  input  logic [9:0] rom_y0,
  input  logic [9:0] rom_x1,
  input  logic [9:0] rom_y1,
`ifdef OBSTACLE_HIT_EN
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       hit,
`endif
  output logic [9:0] a_x,
  output logic [9:0] a_y,
  output logic [9:0] b_x,
  output logic [9:0] b_y,
  output logic       a_active,
  output logic       b_active,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [2:0] rom_index_q, rom_index_d;
  obstacle_t  obs_a_q, obs_a_d, obs_b_q, obs_b_d;
  logic [2:0] lfsr;
  logic       lfsr_advance;

  lane_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(lfsr_advance),
    .value  (lfsr)
  );

`ifdef OBSTACLE_HIT_EN
  logic hit_q, hit_d, hit_any;

  // Collision uses pre-step positions so the player sees what was drawn this frame.
  always_comb begin
    hit_any = (obs_a_q.active && (abs_diff(obs_a_q.x, player_x) < HIT_W) &&
               (abs_diff(obs_a_q.y, player_y) < HIT_H)) ||
              (obs_b_q.active && (abs_diff(obs_b_q.x, player_x) < HIT_W) &&
               (abs_diff(obs_b_q.y, player_y) < HIT_H));
  end
`endif

  always_comb begin
    state_d      = state_q;
    rom_index_d  = rom_index_q;
    obs_a_d      = obs_a_q;
    obs_b_d      = obs_b_q;
    lfsr_advance = 1'b0;
`ifdef OBSTACLE_HIT_EN
    hit_d        = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_advance = 1'b1;
          state_d      = StSelect;
        end
      end
      StSelect: begin
        // Value 7 has no ROM entry; re-roll until a usable index appears.
        if (lfsr == 3'd7) begin
          lfsr_advance = 1'b1;
        end else begin
          rom_index_d = lfsr - 3'd1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        obs_a_d = '{x: rom_x0, y: rom_y0, active: 1'b1, up: (rom_y0 >= Y_MID)};
        obs_b_d = '{x: rom_x1, y: rom_y1, active: 1'b1, up: (rom_y1 >= Y_MID)};
        state_d = StRun;
      end
      StRun: begin
        if (!obs_a_q.active && !obs_b_q.active) begin
          state_d = StDone;
        end else if (frame_tick) begin
`ifdef OBSTACLE_HIT_EN
          if (hit_any) begin
            hit_d          = 1'b1;
            obs_a_d.active = 1'b0;
            obs_b_d.active = 1'b0;
            state_d        = StDone;
          end else
`endif
          begin
            obs_a_d = obstacle_step(obs_a_q, STEP, Y_MAX);
            obs_b_d = obstacle_step(obs_b_q, STEP, Y_MAX);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rom_index_q <= '0;
      obs_a_q     <= '0;
      obs_b_q     <= '0;
`ifdef OBSTACLE_HIT_EN
      hit_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rom_index_q <= rom_index_d;
      obs_a_q     <= obs_a_d;
      obs_b_q     <= obs_b_d;
`ifdef OBSTACLE_HIT_EN
      hit_q       <= hit_d;
`endif
    end
  end

  assign rom_index = rom_index_q;
  assign a_x       = obs_a_q.x;
  assign a_y       = obs_a_q.y;
  assign b_x       = obs_b_q.x;
  assign b_y       = obs_b_q.y;
  assign a_active  = obs_a_q.active;
  assign b_active  = obs_b_q.active;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
`ifdef OBSTACLE_HIT_EN
  assign hit       = hit_q;
`endif

endmodule

// File: tb/tb_obstacle_wave_walker.sv
// Scoreboard bench for obstacle_wave_walker: expected wave loads/finishes are queued by the
// stimulus and checked by a negedge monitor.
module tb_obstacle_wave_walker;
  import obstacle_wave_walker_pkg::*;

  localparam int YMax = 'h262;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] rom_index;
  logic [9:0] rom_x0, rom_y0, rom_x1, rom_y1;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_active, b_active, busy, done;
`ifdef OBSTACLE_HIT_EN
  logic       hit;
`endif

  always #5 clk = ~clk;

  obstacle_wave_walker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_tick(frame_tick),
    .rom_index (rom_index),
    .rom_x0    (rom_x0),
    .rom_y0    (rom_y0),
    .rom_x1    (rom_x1),
    .rom_y1    (rom_y1),
`ifdef OBSTACLE_HIT_EN
    .player_x  (10'h3ff),
    .player_y  (10'h3ff),
    .hit       (hit),
`endif
    .a_x       (a_x),
    .a_y       (a_y),
    .b_x       (b_x),
    .b_y       (b_y),
    .a_active  (a_active),
    .b_active  (b_active),
    .busy      (busy),
    .done      (done)
  );

  // Spawn-position ROM stand-in
  always_comb begin
    rom_x0 = LaneX0; rom_y0 = '0; rom_x1 = LaneX2; rom_y1 = YMaxDef;
    case (rom_index)
      3'd1:    begin rom_x0 = LaneX0; rom_y0 = '0;      rom_x1 = LaneX1; rom_y1 = '0;      end
      3'd2:    begin rom_x0 = LaneX1; rom_y0 = YMaxDef; rom_x1 = LaneX2; rom_y1 = '0;      end
      3'd3:    begin rom_x0 = LaneX2; rom_y0 = YMaxDef; rom_x1 = LaneX1; rom_y1 = YMaxDef; end
      3'd4:    begin rom_x0 = LaneX2; rom_y0 = '0;      rom_x1 = LaneX0; rom_y1 = YMaxDef; end
      3'd5:    begin rom_x0 = LaneX1; rom_y0 = '0;      rom_x1 = LaneX2; rom_y1 = YMaxDef; end
      default: begin rom_x0 = LaneX0; rom_y0 = '0;      rom_x1 = LaneX2; rom_y1 = YMaxDef; end
    endcase
  end

  typedef struct {
    bit is_done;
    int idx;
    int ax, ay, bx, by;
    int lat;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_load(input int idx, input int ax, input int ay, input int bx,
                           input int by, input int lat, input int gap);
    exp_t e;
    e = '{is_done: 1'b0, idx: idx, ax: ax, ay: ay, bx: bx, by: by, lat: lat, gap: gap};
    sb.push_back(e);
  endtask

  task automatic push_done(input int ax, input int ay, input int bx, input int by);
    exp_t e;
    e = '{is_done: 1'b1, idx: 0, ax: ax, ay: ay, bx: bx, by: by, lat: 0, gap: -1};
    sb.push_back(e);
  endtask

  // Monitor: wave start is the first cycle with both obstacles live; wave end is the done pulse.
  int nc = 0, rise_nc = 0, done_nc = -100, gap_now = 0;
  bit busy_prev = 1'b0, load_pend = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    nc++;
    if (!rst_n) begin
      busy_prev = 1'b0;
      load_pend = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        rise_nc   = nc;
        gap_now   = nc - done_nc;
        load_pend = 1'b1;
      end
      if (load_pend && a_active && b_active) begin
        load_pend = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("load_kind", int'(e.is_done), 0);
          chk("load_rom_index", int'(rom_index), e.idx);
          chk("load_a_x", int'(a_x), e.ax);
          chk("load_a_y", int'(a_y), e.ay);
          chk("load_b_x", int'(b_x), e.bx);
          chk("load_b_y", int'(b_y), e.by);
          chk("load_latency", nc - rise_nc, e.lat);
          if (e.gap >= 0) chk("idle_gap", gap_now, e.gap);
        end
      end
      if (done) begin
        done_nc = nc;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", int'(e.is_done), 1);
          chk("done_a_x", int'(a_x), e.ax);
          chk("done_a_y", int'(a_y), e.ay);
          chk("done_b_x", int'(b_x), e.bx);
          chk("done_b_y", int'(b_y), e.by);
          chk("done_actives", int'({a_active, b_active}), 0);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  task automatic wait_run();
    int n = 0;
    while (!(busy && a_active && b_active) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("wait_run_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("wait_done_timeout", 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_x"}, int'(a_x), 0);
    chk({tag, "_a_y"}, int'(a_y), 0);
    chk({tag, "_b_x"}, int'(b_x), 0);
    chk({tag, "_b_y"}, int'(b_y), 0);
    chk({tag, "_actives"}, int'({a_active, b_active}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rom_index"}, int'(rom_index), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    // Wave 1: lfsr 010 -> index 1, both move down
    push_load(1, LaneX0, 0, LaneX1, 0, 2, -1);
    push_done(LaneX0, YMax, LaneX1, YMax);
    pulse_start();
    wait_run();
    ticks(304);
    chk("w1_t304_active", int'({a_active, b_active}), 3);
    chk("w1_t304_a_y", int'(a_y), 'h260);
    ticks(1);
    chk("w1_t305_active", int'({a_active, b_active}), 0);
    chk("w1_t305_a_y", int'(a_y), YMax);
    chk("w1_retire_no_done_yet", int'(done), 0);
    wait_idle();

    // Wave 2: lfsr 101 -> index 4, A down, B up
    push_load(4, LaneX2, 0, LaneX0, YMax, 2, -1);
    push_done(LaneX2, YMax, LaneX0, 0);
    pulse_start();
    wait_run();
    ticks(1);
    chk("w2_t1_a_y", int'(a_y), 2);
    chk("w2_t1_b_y", int'(b_y), 'h260);
    ticks(304);
    wait_idle();

    // Wave 3: lfsr 011 -> index 2
    push_load(2, LaneX1, YMax, LaneX2, 0, 2, -1);
    push_done(LaneX1, 0, LaneX2, YMax);
    pulse_start();
    wait_run();
    ticks(305);
    wait_idle();

    // Wave 4 skips 111 (index 5, one extra cycle); start held so wave 5 (index 3) follows
    push_load(5, LaneX1, 0, LaneX2, YMax, 3, -1);
    push_done(LaneX1, YMax, LaneX2, 0);
    push_load(3, LaneX2, YMax, LaneX1, YMax, 2, 2);
    push_done(LaneX2, 0, LaneX1, 0);
    @(posedge clk); #1 frame_tick = 1'b1; start = 1'b1;
    wait_done();
    wait_idle();
    wait_run();
    start = 1'b0;
    wait_done();
    @(posedge clk); #1 frame_tick = 1'b0;
    wait_idle();

    // Wave 6: index 0, aborted by reset mid-wave
    push_load(0, LaneX0, 0, LaneX2, YMax, 2, -1);
    pulse_start();
    wait_run();
    ticks(100);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 chk_all_zero("abort");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("abort_stays_idle", int'({busy, done}), 0);

    // Wave 7: lfsr back at seed, so index 1 again
    push_load(1, LaneX0, 0, LaneX1, 0, 2, -1);
    push_done(LaneX0, YMax, LaneX1, YMax);
    pulse_start();
    wait_run();
    ticks(305);
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
